// File: rtl/d_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Direction encoding matches the data memory's dir input.
package d_mem_arbiter_pkg;

    localparam logic DIRECTION_READ  = 1'b0;
    localparam logic DIRECTION_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/d_mem_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright,
// and a tie goes to the requester that was not served last.
module d_mem_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       pick
);

    // Select the winner from the request vector and last-served owner.
    always_comb begin
        valid = |req;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/d_mem_arbiter.sv
// Shares one data-memory port between two requesters with round-robin
// fairness, a forced release cycle between transactions and a timeout.
module d_mem_arbiter
    import d_mem_arbiter_pkg::*;
#(
    parameter int d_addr_width   = 8,
    parameter int timeout_cycles = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s0_req,
    input  logic                    s0_dir,
    input  logic [d_addr_width-1:0] s0_addr,
    input  logic [7:0]              s0_wdata,
    output logic                    s0_ack,
    output logic [7:0]              s0_rdata,
    input  logic                    s1_req,
    input  logic                    s1_dir,
    input  logic [d_addr_width-1:0] s1_addr,
    input  logic [7:0]              s1_wdata,
    output logic                    s1_ack,
    output logic [7:0]              s1_rdata,
    output logic                    m_req,
    output logic                    m_dir,
    output logic [d_addr_width-1:0] m_addr,
    output logic [7:0]              m_wdata,
    input  logic                    m_ack,
    input  logic [7:0]              m_rdata,
    output logic                    timeout_err
);

    localparam int                CNT_W    = $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(timeout_cycles - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_e        state_r;
    logic              grant_r;
    logic              last_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              pick_valid_s;
    logic              pick_s;
    logic              busy_s;
    logic              req_g_s;
    logic              timeout_hit_s;

    d_mem_rr_pick u_pick (
        .req   ({s1_req, s0_req}),
        .last  (last_r),
        .valid (pick_valid_s),
        .pick  (pick_s)
    );

    assign busy_s        = (state_r == ST_BUSY);
    assign req_g_s       = grant_r ? s1_req : s0_req;
    // Ack and a dropped request take precedence over the timeout.
    assign timeout_hit_s = busy_s & req_g_s & ~m_ack & (cnt_r == CNT_LAST);
    assign timeout_err   = timeout_hit_s;
    assign s0_rdata      = m_rdata;
    assign s1_rdata      = m_rdata;

    // Memory-side mux; outside BUSY the port is parked as a read of address 0.
    always_comb begin
        m_req   = 1'b0;
        m_dir   = DIRECTION_READ;
        m_addr  = {d_addr_width{1'b0}};
        m_wdata = 8'h00;
        s0_ack  = 1'b0;
        s1_ack  = 1'b0;
        if (busy_s) begin
            m_req   = 1'b1;
            m_dir   = grant_r ? s1_dir   : s0_dir;
            m_addr  = grant_r ? s1_addr  : s0_addr;
            m_wdata = grant_r ? s1_wdata : s0_wdata;
            s0_ack  = m_ack & s0_req & ~grant_r;
            s1_ack  = m_ack & s1_req &  grant_r;
        end else begin
            m_req   = 1'b0;
        end
    end

    // Arbitration FSM with grant ownership and BUSY-cycle watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            grant_r <= 1'b0;
            last_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        grant_r <= pick_s;
                        last_r  <= pick_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (m_ack || !req_g_s || (cnt_r == CNT_LAST)) begin
                        state_r <= ST_RELEASE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RELEASE: state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed and randomized bench for d_mem_arbiter against a
// transaction-level model of arbitration order and memory contents.
module tb_d_mem_arbiter;
    import d_mem_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       s0_req, s0_dir, s1_req, s1_dir;
    logic [7:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic       s0_ack, s1_ack;
    logic [7:0] s0_rdata, s1_rdata;
    logic       m_req, m_dir;
    logic [7:0] m_addr, m_wdata;
    logic       m_ack = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       timeout_err;

    logic       ack_en = 1'b1;
    logic [7:0] mem     [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic       ref_last;
    int         vectors = 0;
    int         miscompares = 0;

    d_mem_arbiter #(.d_addr_width(8), .timeout_cycles(16)) dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_dir(s0_dir), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_ack(s0_ack), .s0_rdata(s0_rdata),
        .s1_req(s1_req), .s1_dir(s1_dir), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_ack(s1_ack), .s1_rdata(s1_rdata),
        .m_req(m_req), .m_dir(m_dir), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Single-cycle memory; its write enable follows dir alone, not req.
    always @(posedge clk) begin
        if (m_dir == DIRECTION_WRITE) mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
        m_ack   <= ack_en & m_req & ~m_ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One arbitrated transaction starting in IDLE; the winner follows the
    // round-robin rule and reads must return the model's memory contents.
    task automatic do_txn(input logic r0, input logic r1, input logic d0, input logic d1,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] w0, input logic [7:0] w1);
        logic       w;
        logic       dw;
        logic [7:0] aw, ww;
        w  = (r0 && r1) ? ~ref_last : r1;
        dw = w ? d1 : d0;
        aw = w ? a1 : a0;
        ww = w ? w1 : w0;
        s0_req = r0; s0_dir = d0; s0_addr = a0; s0_wdata = w0;
        s1_req = r1; s1_dir = d1; s1_addr = a1; s1_wdata = w1;
        tick();
        chk("grant_mreq", m_req, 1);
        chk("grant_dir", m_dir, dw);
        chk("grant_addr", m_addr, aw);
        chk("grant_wdata", m_wdata, ww);
        chk("early_ack", {s1_ack, s0_ack}, 0);
        tick();
        chk("ack_owner", {s1_ack, s0_ack}, w ? 2'b10 : 2'b01);
        chk("ack_tmo_quiet", timeout_err, 0);
        if (dw == DIRECTION_READ) chk("rdata", w ? s1_rdata : s0_rdata, ref_mem[aw]);
        else ref_mem[aw] = ww;
        s0_req = 1'b0; s1_req = 1'b0;
        tick();
        chk("release_mreq", m_req, 0);
        chk("release_dir", m_dir, DIRECTION_READ);
        chk("release_ack", {s1_ack, s0_ack}, 0);
        tick();
        ref_last = w;
    endtask

    initial begin
        rst = 1'b1;
        s0_req = 1'b0; s0_dir = DIRECTION_READ; s0_addr = 8'h00; s0_wdata = 8'h00;
        s1_req = 1'b0; s1_dir = DIRECTION_READ; s1_addr = 8'h00; s1_wdata = 8'h00;
        ref_last = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_mreq", m_req, 0);
            chk("idle_dir", m_dir, DIRECTION_READ);
            chk("idle_addr", m_addr, 0);
            chk("idle_acks", {s1_ack, s0_ack}, 0);
            chk("idle_tmo", timeout_err, 0);
        end

        // Contention: first tie after reset goes to requester 0, then alternates
        for (int i = 0; i < 8; i++)
            do_txn(1'b1, 1'b1, DIRECTION_READ, DIRECTION_READ,
                   8'($urandom), 8'($urandom), 8'h00, 8'h00);

        // Idle write guard: s1 parks a write with req low
        s1_dir = DIRECTION_WRITE; s1_wdata = 8'hFF; s1_addr = 8'h20;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("guard_dir", m_dir, DIRECTION_READ);
            chk("guard_mreq", m_req, 0);
        end
        do_txn(1'b1, 1'b0, DIRECTION_READ, DIRECTION_WRITE, 8'h20, 8'h20, 8'h00, 8'hFF);
        chk("guard_mem", mem[8'h20], 8'h00);

        // Single write then read
        do_txn(1'b1, 1'b0, DIRECTION_WRITE, DIRECTION_READ, 8'h10, 8'h00, 8'hA5, 8'h00);
        do_txn(1'b1, 1'b0, DIRECTION_READ, DIRECTION_READ, 8'h10, 8'h00, 8'h00, 8'h00);

        // Timeout: memory never acks
        ack_en = 1'b0;
        s1_req = 1'b1; s1_dir = DIRECTION_READ; s1_addr = 8'h33;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("tmo_mreq", m_req, 1);
            chk("tmo_pulse", timeout_err, (k == 16) ? 1 : 0);
            chk("tmo_noack", s1_ack, 0);
        end
        tick();
        chk("tmo_release", m_req, 0);
        chk("tmo_pulse_end", timeout_err, 0);
        s1_req = 1'b0;
        tick();
        ref_last = 1'b1;
        ack_en = 1'b1;
        do_txn(1'b0, 1'b1, DIRECTION_READ, DIRECTION_READ, 8'h00, 8'h10, 8'h00, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [1:0] pat;
            pat = 2'($urandom_range(1, 3));
            do_txn(pat[0], pat[1], 1'($urandom), 1'($urandom),
                   8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                   8'($urandom), 8'($urandom));
        end

        // Reset mid-operation with an ack pending
        s0_req = 1'b1; s0_dir = DIRECTION_READ; s0_addr = 8'h05;
        tick();
        chk("midrst_busy", m_req, 1);
        rst = 1'b1;
        tick();
        chk("midrst_mreq", m_req, 0);
        chk("midrst_dir", m_dir, DIRECTION_READ);
        chk("midrst_acks", {s1_ack, s0_ack}, 0);
        chk("midrst_tmo", timeout_err, 0);
        rst = 1'b0; s0_req = 1'b0;
        tick();
        ref_last = 1'b1;
        do_txn(1'b1, 1'b1, DIRECTION_READ, DIRECTION_READ, 8'h10, 8'h20, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
